// File: rtl/sprite_blitter_pkg.sv
// Shared definitions for the sprite blitter: screen geometry defaults,
// coordinate/colour widths, FSM state encoding and an on-screen test helper.
package sprite_blitter_pkg;

  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;
  localparam int SCR_XW       = 8;
  localparam int SCR_YW       = 7;
  localparam int COLOUR_W     = 3;
  localparam int SUM_W        = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // True when a 9-bit screen coordinate pair lies inside the visible area.
  function automatic logic pix_on_screen(input logic [SUM_W-1:0] i_sx,
                                         input logic [SUM_W-1:0] i_sy,
                                         input int i_w, input int i_h);
    return (int'(i_sx) < i_w) && (int'(i_sy) < i_h);
  endfunction

endpackage

// File: rtl/sprite_blitter_scan_counter.sv
// Row-major sprite coordinate counter (x fastest). Held at (0,0) while not
// enabled, so each draw starts from the origin; o_last flags the final pixel.
module sprite_blitter_scan_counter #(
  parameter int WIDTH_X  = 4,
  parameter int WIDTH_Y  = 3,
  parameter int SPRITE_W = 10,
  parameter int SPRITE_H = 6
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               i_en,
  output logic [WIDTH_X-1:0] o_x,
  output logic [WIDTH_Y-1:0] o_y,
  output logic               o_last
);

  logic [WIDTH_X-1:0] r_x;
  logic [WIDTH_Y-1:0] r_y;
  logic               w_x_end;
  logic               w_y_end;

  assign w_x_end = (r_x == WIDTH_X'(SPRITE_W - 1));
  assign w_y_end = (r_y == WIDTH_Y'(SPRITE_H - 1));
  assign o_last  = w_x_end && w_y_end;
  assign o_x     = r_x;
  assign o_y     = r_y;

  // Advance x each enabled cycle, wrap into the next row, clear when idle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_x <= '0;
      r_y <= '0;
    end else if (!i_en) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_x_end) begin
      r_x <= '0;
      r_y <= w_y_end ? '0 : r_y + WIDTH_Y'(1);
    end else begin
      r_x <= r_x + WIDTH_X'(1);
    end
  end

endmodule

// File: rtl/sprite_blitter.sv
// Sprite blitter: scans a sprite out of its RAM, offsets each pixel by the
// latched screen position, clips off-screen pixels and drives the VGA plotter.
// Optional: define SPRITE_BLITTER_TRANSPARENCY_EN to suppress pixels whose
// colour equals TRANSPARENT (slot still consumed, timing unchanged).
module sprite_blitter
  import sprite_blitter_pkg::*;
#(
  parameter int         WIDTH_X     = 4,
  parameter int         WIDTH_Y     = 3,
  parameter int         SPRITE_W    = 10,
  parameter int         SPRITE_H    = 6,
  parameter int         SCREEN_W    = SCREEN_W_DEF,
  parameter int         SCREEN_H    = SCREEN_H_DEF,
  parameter logic [2:0] TRANSPARENT = 3'b000
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [7:0]         pos_x,
  input  logic [6:0]         pos_y,
  output logic [WIDTH_X-1:0] spr_x,
  output logic [WIDTH_Y-1:0] spr_y,
  input  logic [2:0]         spr_color,
  output logic [7:0]         vga_x,
  output logic [6:0]         vga_y,
  output logic [2:0]         vga_colour,
  output logic               vga_plot,
  output logic               busy,
  output logic               done
);

  state_t               r_state;
  state_t               w_state_next;
  logic                 r_flush_cnt;
  logic                 w_flush_cnt_next;
  logic                 w_accept;
  logic                 w_scan_en;
  logic                 w_last;
  logic [SCR_XW-1:0]    r_pos_x;
  logic [SCR_YW-1:0]    r_pos_y;
  logic                 r_s1_valid;
  logic [WIDTH_X-1:0]   r_s1_x;
  logic [WIDTH_Y-1:0]   r_s1_y;
  logic [SUM_W-1:0]     w_sx;
  logic [SUM_W-1:0]     w_sy;
  logic                 w_opaque;
  logic                 w_hit;
  logic [SCR_XW-1:0]    r_vga_x;
  logic [SCR_YW-1:0]    r_vga_y;
  logic [COLOUR_W-1:0]  r_vga_colour;
  logic                 r_vga_plot;

  assign w_scan_en = (r_state == ST_SCAN);

  sprite_blitter_scan_counter #(
    .WIDTH_X  (WIDTH_X),
    .WIDTH_Y  (WIDTH_Y),
    .SPRITE_W (SPRITE_W),
    .SPRITE_H (SPRITE_H)
  ) u_scan (
    .clk    (clk),
    .resetn (resetn),
    .i_en   (w_scan_en),
    .o_x    (spr_x),
    .o_y    (spr_y),
    .o_last (w_last)
  );

  // State and flush-slot registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_flush_cnt <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_flush_cnt <= w_flush_cnt_next;
    end
  end

  // Next-state logic; FLUSH lasts two cycles to drain the two pipeline stages.
  always_comb begin
    w_state_next     = r_state;
    w_flush_cnt_next = 1'b0;
    w_accept         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (w_last) w_state_next = ST_FLUSH;
      end
      ST_FLUSH: begin
        w_flush_cnt_next = ~r_flush_cnt;
        if (r_flush_cnt) w_state_next = ST_DONE;
      end
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Capture the screen offset when a draw is accepted.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pos_x <= '0;
      r_pos_y <= '0;
    end else if (w_accept) begin
      r_pos_x <= pos_x;
      r_pos_y <= pos_y;
    end
  end

  // Stage 1: carry the issued coordinate alongside the one-cycle RAM read.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_s1_valid <= 1'b0;
      r_s1_x     <= '0;
      r_s1_y     <= '0;
    end else begin
      r_s1_valid <= w_scan_en;
      r_s1_x     <= spr_x;
      r_s1_y     <= spr_y;
    end
  end

  assign w_sx = SUM_W'(r_pos_x) + SUM_W'(r_s1_x);
  assign w_sy = SUM_W'(r_pos_y) + SUM_W'(r_s1_y);

`ifdef SPRITE_BLITTER_TRANSPARENCY_EN
  assign w_opaque = (spr_color != TRANSPARENT);
`else
  assign w_opaque = 1'b1;
`endif

  assign w_hit = r_s1_valid && w_opaque && pix_on_screen(w_sx, w_sy, SCREEN_W, SCREEN_H);

  // Stage 2: register visible pixels; clipped slots leave position/colour untouched.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_vga_x      <= '0;
      r_vga_y      <= '0;
      r_vga_colour <= '0;
      r_vga_plot   <= 1'b0;
    end else begin
      r_vga_plot <= w_hit;
      if (w_hit) begin
        r_vga_x      <= w_sx[SCR_XW-1:0];
        r_vga_y      <= w_sy[SCR_YW-1:0];
        r_vga_colour <= spr_color;
      end
    end
  end

  assign vga_x      = r_vga_x;
  assign vga_y      = r_vga_y;
  assign vga_colour = r_vga_colour;
  assign vga_plot   = r_vga_plot;
  assign busy       = (r_state != ST_IDLE);
  assign done       = (r_state == ST_DONE);

endmodule

// File: tb/tb_sprite_blitter.sv
// Scoreboard bench for sprite_blitter: the driver pushes expected plots and
// busy/done windows computed from the sprite geometry; a negedge monitor
// pops and compares whenever the DUT plots a pixel.
module tb_sprite_blitter;

  localparam int SW = 10;
  localparam int SH = 6;
  localparam int N  = SW * SH;
  localparam int TL = 8192;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       start = 1'b0;
  logic [7:0] pos_x = '0;
  logic [6:0] pos_y = '0;
  logic [3:0] spr_x;
  logic [2:0] spr_y;
  logic [2:0] spr_color = '0;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       busy;
  logic       done;

  sprite_blitter dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .spr_x      (spr_x),
    .spr_y      (spr_y),
    .spr_color  (spr_color),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt++;

  // Sprite RAM model: colour pattern selectable per draw, one-cycle read.
  int         ram_mode = 3;
  logic [2:0] rand_tab [0:15][0:7];

  function automatic logic [2:0] ram_colour(input int x, input int y);
    case (ram_mode)
      0:       return 3'((x + y) % 8);
      1:       return (x % 2 == 0) ? 3'd0 : 3'(((x + y) % 7) + 1);
      2:       return rand_tab[x][y];
      default: return 3'(((x + y) % 7) + 1);
    endcase
  endfunction

  always @(posedge clk) spr_color <= ram_colour(int'(spr_x), int'(spr_y));

  typedef struct {
    int t;
    int x;
    int y;
    int c;
  } pix_t;

  pix_t exp_q[$];
  bit   exp_busy [0:TL-1];
  bit   exp_done [0:TL-1];
  int   total = 0;
  int   bad = 0;
  int   plot_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, req, edge_cnt);
    end
  endtask

  // Reference: every sprite pixel k lands at screen (pos+x, pos+y) two cycles after
  // it is issued; issue of k happens k cycles after acceptance edge a.
  task automatic expect_draw(input int a, input int px, input int py, output int plots);
    plots = 0;
    for (int k = 0; k < N; k++) begin
      int x, y, sx, sy, c;
      bit vis;
      x = k % SW;
      y = k / SW;
      sx = px + x;
      sy = py + y;
      c = int'(ram_colour(x, y));
      vis = (sx < 160) && (sy < 120);
`ifdef SPRITE_BLITTER_TRANSPARENCY_EN
      if (c == 0) vis = 1'b0;
`endif
      if (vis) begin
        exp_q.push_back('{t: a + k + 2, x: sx, y: sy, c: c});
        plots++;
      end
    end
    for (int t = a; t <= a + N + 2; t++) exp_busy[t] = 1'b1;
    exp_done[a + N + 2] = 1'b1;
  endtask

  // Monitor: per-cycle busy/done against the expected windows, plots against the queue.
  always @(negedge clk) begin
    if (edge_cnt < TL) begin
      check("busy", 32'(busy), 32'(exp_busy[edge_cnt]));
      check("done", 32'(done), 32'(exp_done[edge_cnt]));
    end
    while (exp_q.size() > 0 && exp_q[0].t < edge_cnt) begin
      total++;
      bad++;
      $display("FAIL missed_plot: got none expected t=%0d (%0d,%0d) c=%0d",
               exp_q[0].t, exp_q[0].x, exp_q[0].y, exp_q[0].c);
      void'(exp_q.pop_front());
    end
    if (vga_plot === 1'b1) begin
      plot_cnt++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_plot: got t=%0d (%0d,%0d) c=%0d expected no plot",
                 edge_cnt, vga_x, vga_y, vga_colour);
      end else begin
        pix_t e;
        e = exp_q.pop_front();
        if (e.t != edge_cnt || int'(vga_x) != e.x || int'(vga_y) != e.y || int'(vga_colour) != e.c) begin
          bad++;
          $display("FAIL plot: got t=%0d (%0d,%0d) c=%0d expected t=%0d (%0d,%0d) c=%0d",
                   edge_cnt, vga_x, vga_y, vga_colour, e.t, e.x, e.y, e.c);
        end
      end
    end else begin
      check("plot_level", 32'(vga_plot), 32'd0);
    end
  end

  // One draw with a single-cycle start; req_plots < 0 means use the model's count.
  task automatic draw(input int px, input int py, input int req_plots);
    int a, n;
    @(negedge clk); #1;
    pos_x = 8'(px);
    pos_y = 7'(py);
    start = 1'b1;
    a = edge_cnt + 1;
    expect_draw(a, px, py, n);
    plot_cnt = 0;
    @(posedge clk);
    @(negedge clk); #1;
    start = 1'b0;
    while (edge_cnt < a + N + 4) @(negedge clk);
    #1;
    check("plot_count", 32'(plot_cnt), 32'((req_plots < 0) ? n : req_plots));
    $display("draw pos=(%0d,%0d) mode=%0d accepted_edge=%0d plots=%0d", px, py, ram_mode, a, plot_cnt);
  endtask

  initial begin
    int a, n1, n2;
    #1 resetn = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_plot", 32'(vga_plot), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_vga_xy", {vga_x, vga_y}, 32'd0);
    check("rst_spr_xy", {spr_x, spr_y}, 32'd0);
    resetn = 1'b1;

    // Basic draw, colours never zero so both builds plot all 60.
    ram_mode = 3;
    draw(20, 30, 60);
    // Colour = (x+y)&7 to confirm RAM latency alignment.
    ram_mode = 0;
    draw(20, 30, -1);
    // Bottom-right clipping: 5 columns x 3 rows visible.
    ram_mode = 3;
    draw(155, 117, 15);
    // Zero colour on even x.
    ram_mode = 1;
`ifdef SPRITE_BLITTER_TRANSPARENCY_EN
    draw(20, 30, 30);
`else
    draw(20, 30, 60);
`endif

    // Start held high: second draw accepted N+4 edges after the first.
    ram_mode = 3;
    @(negedge clk); #1;
    pos_x = 8'd20;
    pos_y = 7'd30;
    start = 1'b1;
    a = edge_cnt + 1;
    expect_draw(a, 20, 30, n1);
    expect_draw(a + N + 4, 20, 30, n2);
    plot_cnt = 0;
    repeat (100) @(negedge clk);
    #1 start = 1'b0;
    while (edge_cnt < a + 2 * (N + 4)) @(negedge clk);
    #1;
    check("held_plot_count", 32'(plot_cnt), 32'd120);
    $display("held start accepted_edges=%0d,%0d plots=%0d", a, a + N + 4, plot_cnt);

    // Reset in the middle of a draw, then a clean full draw.
    @(negedge clk); #1;
    pos_x = 8'd40;
    pos_y = 7'd50;
    start = 1'b1;
    a = edge_cnt + 1;
    expect_draw(a, 40, 50, n1);
    @(posedge clk);
    @(negedge clk); #1;
    start = 1'b0;
    while (edge_cnt < a + 19) @(negedge clk);
    #1;
    exp_q.delete();
    for (int t = edge_cnt; t < TL; t++) begin
      exp_busy[t] = 1'b0;
      exp_done[t] = 1'b0;
    end
    resetn = 1'b0;
    #1;
    check("mid_rst_plot", 32'(vga_plot), 32'd0);
    check("mid_rst_busy_done", {busy, done}, 32'd0);
    check("mid_rst_vga", {vga_x, vga_y, vga_colour}, 32'd0);
    check("mid_rst_spr", {spr_x, spr_y}, 32'd0);
    $display("reset asserted at edge %0d of draw", edge_cnt - a + 1);
    repeat (2) @(negedge clk);
    #1 resetn = 1'b1;
    draw(40, 50, 60);

    // Randomized colours and positions (including off-screen corners).
    ram_mode = 2;
    for (int i = 0; i < 6; i++) begin
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 8; y++)
          rand_tab[x][y] = 3'($urandom_range(0, 7));
      draw(int'($urandom_range(0, 255)), int'($urandom_range(0, 127)), -1);
    end

    repeat (5) @(negedge clk);
    #1;
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
